pdm_cic_decimator: RTL and testbench

Front-end stage of the feedback-suppression audio path. It generates the clock for a PDM MEMS microphone and captures the 1-bit PDM stream. A 3rd-order CIC filter decimates the stream to 8-bit two's-complement PCM samples with a single-cycle valid strobe. Its o_data/o_valid feed the FeedbackSupressor's sample input directly.

---
 rtl/fb_audio_pkg.sv | 8 +
 rtl/pdm_clk_gen.sv | 31 +++
 rtl/pdm_cic_decimator.sv | 78 +++++++
 tb/tb_pdm_cic_decimator.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fb_audio_pkg.sv
// fb_audio_pkg: constants shared across the feedback-suppression audio path
package fb_audio_pkg;
  localparam int CIC_ORDER = 3;
  localparam int SAMPLE_W = 8;
  function automatic int cic_width(input int decim_log2);
    return CIC_ORDER * decim_log2 + 1;
  endfunction
endpackage

// File: rtl/pdm_clk_gen.sv
// pdm_clk_gen: PDM microphone clock divider, sample strobe and data synchronizer
module pdm_clk_gen #(
  parameter int PDM_CLK_DIV = 10
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_enable,
  input  logic i_pdm_data,
  output logic o_pdm_clk,
  output logic o_strobe,
  output logic o_bit
);
  localparam int CW = $clog2(PDM_CLK_DIV);
  localparam int HALF = PDM_CLK_DIV / 2;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0] sync;
  assign cnt_nxt = (cnt == CW'(PDM_CLK_DIV - 1)) ? '0 : cnt + CW'(1);
  // last high-phase cycle gives the mic the most settling time before capture
  assign o_strobe = i_enable && cnt == CW'(HALF - 1);
  assign o_bit = sync[1];
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      cnt <= '0;
      o_pdm_clk <= 1'b0;
      sync <= '0;
    end else begin
      sync <= {sync[0], i_pdm_data};
      cnt <= i_enable ? cnt_nxt : '0;
      o_pdm_clk <= i_enable && cnt_nxt < CW'(HALF);
    end
endmodule

// File: rtl/pdm_cic_decimator.sv
// pdm_cic_decimator: PDM mic front end with 3rd-order CIC decimation to 8-bit PCM
module pdm_cic_decimator
  import fb_audio_pkg::*;
#(
  parameter int PDM_CLK_DIV = 10,
  parameter int DECIM_LOG2 = 6
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_enable,
  output logic                o_pdm_clk,
  input  logic                i_pdm_data,
  output logic [SAMPLE_W-1:0] o_data,
  output logic                o_valid,
  output logic                o_clip
);
  localparam int W = cic_width(DECIM_LOG2);
  logic strobe, pdm_bit, blk, v1, v2, v3, emit;
  logic [DECIM_LOG2-1:0] dcnt;
  logic [1:0] wu;
  logic [W-1:0] i1, i2, i3, d1, d2, d3, c1, c2, c3;
  logic [W-2:0] u;
  logic [W+SAMPLE_W-2:0] ext;
  pdm_clk_gen #(.PDM_CLK_DIV(PDM_CLK_DIV)) u_clk_gen (
    .i_clk(i_clk),
    .i_reset_n(i_reset_n),
    .i_enable(i_enable),
    .i_pdm_data(i_pdm_data),
    .o_pdm_clk(o_pdm_clk),
    .o_strobe(strobe),
    .o_bit(pdm_bit)
  );
  // only full scale sets the top bit; clamp it to the largest in-range code
  assign u = c3[W-1] ? '1 : c3[W-2:0];
  assign ext = {u, {SAMPLE_W{1'b0}}};
  assign emit = v3 && wu == 2'd3;
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      {i1, i2, i3, d1, d2, d3, c1, c2, c3} <= '0;
      {blk, v1, v2, v3, o_valid, o_clip} <= '0;
      dcnt <= '0;
      wu <= '0;
      o_data <= '0;
    end else if (!i_enable) begin
      {i1, i2, i3, d1, d2, d3, c1, c2, c3} <= '0;
      {blk, v1, v2, v3, o_valid, o_clip} <= '0;
      dcnt <= '0;
      wu <= '0;
      o_data <= '0;
    end else begin
      if (strobe) begin
        i1 <= i1 + W'(pdm_bit);
        i2 <= i2 + i1;
        i3 <= i3 + i2;
        dcnt <= dcnt + DECIM_LOG2'(1);
      end
      blk <= strobe && &dcnt;
      {v1, v2, v3} <= {blk, v1, v2};
      if (blk) begin
        c1 <= i3 - d1;
        d1 <= i3;
      end
      if (v1) begin
        c2 <= c1 - d2;
        d2 <= c1;
      end
      if (v2) begin
        c3 <= c2 - d3;
        d3 <= c2;
      end
      if (v3 && wu != 2'd3) wu <= wu + 2'd1;
      o_valid <= emit;
      if (emit) begin
        o_data <= {~ext[W+SAMPLE_W-2], ext[W+SAMPLE_W-3 -: SAMPLE_W-1]};
        o_clip <= c3[W-1];
      end
    end
endmodule

// File: tb/tb_pdm_cic_decimator.sv
// tb_pdm_cic_decimator: directed self-checking bench for the PDM CIC decimator
module tb_pdm_cic_decimator;
  logic i_clk = 1'b0, i_reset_n = 1'b0, i_enable = 1'b0, i_pdm_data = 1'b0;
  logic o_pdm_clk, o_valid, o_clip;
  logic [7:0] o_data;
  int checks = 0, fails = 0;
  always #5 i_clk = ~i_clk;
  pdm_cic_decimator dut (
    .i_clk(i_clk),
    .i_reset_n(i_reset_n),
    .i_enable(i_enable),
    .o_pdm_clk(o_pdm_clk),
    .i_pdm_data(i_pdm_data),
    .o_data(o_data),
    .o_valid(o_valid),
    .o_clip(o_clip)
  );
  task automatic wait_valid(input int limit, output int n);
    n = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge i_clk);
      if (o_valid) begin
        n = i;
        break;
      end
    end
  endtask
  task automatic start();
    i_enable = 1'b0;
    repeat (3) @(negedge i_clk);
    i_enable = 1'b1;
  endtask
  task automatic test_reset();
    repeat (2) @(negedge i_clk);
    checks++;
    if ({o_data, o_valid, o_clip, o_pdm_clk} !== 11'd0) begin
      fails++;
      $display("FAIL reset_state: got data=%h valid=%b clip=%b pdm=%b want all 0", o_data, o_valid, o_clip, o_pdm_clk);
    end
    i_reset_n = 1'b1;
  endtask
  task automatic test_pdm_clk();
    logic exp;
    i_pdm_data = 1'b0;
    start();
    for (int i = 0; i < 30; i++) begin
      @(negedge i_clk);
      exp = (i % 10 == 9) || (i % 10 < 4);
      checks++;
      if (o_pdm_clk !== exp) begin
        fails++;
        $display("FAIL pdm_clk_cycle%0d: got %b want %b", i, o_pdm_clk, exp);
      end
    end
  endtask
  task automatic test_const(input logic b, input logic [7:0] exp_data, input logic exp_clip);
    int n;
    i_pdm_data = b;
    start();
    wait_valid(3000, n);
    checks++;
    if (n !== 2558) begin
      fails++;
      $display("FAIL const%0b_first_valid: got cycle %0d want 2558", b, n);
    end
    checks++;
    if (o_data !== exp_data || o_clip !== exp_clip) begin
      fails++;
      $display("FAIL const%0b_first_sample: got data=%h clip=%b want data=%h clip=%b", b, o_data, o_clip, exp_data, exp_clip);
    end
    @(negedge i_clk);
    checks++;
    if (o_valid !== 1'b0) begin
      fails++;
      $display("FAIL const%0b_single_cycle_valid: got %b want 0", b, o_valid);
    end
    checks++;
    if (o_data !== exp_data || o_clip !== exp_clip) begin
      fails++;
      $display("FAIL const%0b_hold: got data=%h clip=%b want data=%h clip=%b", b, o_data, o_clip, exp_data, exp_clip);
    end
    wait_valid(700, n);
    checks++;
    if (n !== 638) begin
      fails++;
      $display("FAIL const%0b_second_valid: got offset %0d want 638", b, n);
    end
    checks++;
    if (o_data !== exp_data || o_clip !== exp_clip) begin
      fails++;
      $display("FAIL const%0b_second_sample: got data=%h clip=%b want data=%h clip=%b", b, o_data, o_clip, exp_data, exp_clip);
    end
  endtask
  task automatic test_alternating();
    int last, pulses, rises;
    logic prev;
    i_pdm_data = 1'b0;
    start();
    last = -1;
    pulses = 0;
    rises = 0;
    prev = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge i_clk);
      if (i % 10 == 7) i_pdm_data = ~i_pdm_data;
      if (o_pdm_clk && !prev) rises++;
      prev = o_pdm_clk;
      if (o_valid) begin
        checks++;
        if ((last < 0 && i !== 2558) || (last >= 0 && i - last !== 640)) begin
          fails++;
          $display("FAIL alt_spacing%0d: got cycle %0d (prev %0d) want 2558 then +640", pulses, i, last);
        end
        if (last >= 0) begin
          checks++;
          if (rises !== 64) begin
            fails++;
            $display("FAIL alt_strobes%0d: got %0d pdm clocks want 64", pulses, rises);
          end
        end
        checks++;
        if (o_data !== 8'h00 || o_clip !== 1'b0) begin
          fails++;
          $display("FAIL alt_sample%0d: got data=%h clip=%b want data=00 clip=0", pulses, o_data, o_clip);
        end
        last = i;
        rises = 0;
        pulses++;
      end
    end
    checks++;
    if (pulses !== 3) begin
      fails++;
      $display("FAIL alt_pulse_count: got %0d want 3", pulses);
    end
  endtask
  task automatic test_reset_mid();
    int n;
    i_pdm_data = 1'b1;
    start();
    repeat (5000) @(negedge i_clk);
    checks++;
    if (o_data !== 8'h7F) begin
      fails++;
      $display("FAIL pre_reset_data: got %h want 7f", o_data);
    end
    i_reset_n = 1'b0;
    #1;
    checks++;
    if ({o_data, o_valid, o_clip, o_pdm_clk} !== 11'd0) begin
      fails++;
      $display("FAIL async_reset_clear: got data=%h valid=%b clip=%b pdm=%b want all 0", o_data, o_valid, o_clip, o_pdm_clk);
    end
    repeat (3) @(negedge i_clk);
    checks++;
    if ({o_data, o_valid, o_clip, o_pdm_clk} !== 11'd0) begin
      fails++;
      $display("FAIL reset_hold: got data=%h valid=%b clip=%b pdm=%b want all 0", o_data, o_valid, o_clip, o_pdm_clk);
    end
    i_reset_n = 1'b1;
    wait_valid(3000, n);
    checks++;
    if (n !== 2558) begin
      fails++;
      $display("FAIL reset_release_first_valid: got cycle %0d want 2558", n);
    end
    checks++;
    if (o_data !== 8'h7F || o_clip !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_sample: got data=%h clip=%b want data=7f clip=1", o_data, o_clip);
    end
  endtask
  task automatic test_enable_drop();
    int n, bad;
    wait_valid(700, n);
    repeat (300) @(negedge i_clk);
    i_enable = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge i_clk);
      if (o_pdm_clk !== 1'b0 || o_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL enable_low_idle: got %0d active cycles want 0", bad);
    end
    checks++;
    if (o_data !== 8'h00 || o_clip !== 1'b0) begin
      fails++;
      $display("FAIL enable_low_clear: got data=%h clip=%b want data=00 clip=0", o_data, o_clip);
    end
    i_enable = 1'b1;
    wait_valid(3000, n);
    checks++;
    if (n !== 2558) begin
      fails++;
      $display("FAIL enable_rise_first_valid: got cycle %0d want 2558", n);
    end
    checks++;
    if (o_data !== 8'h7F || o_clip !== 1'b1) begin
      fails++;
      $display("FAIL enable_rise_sample: got data=%h clip=%b want data=7f clip=1", o_data, o_clip);
    end
  endtask
  initial begin
    test_reset();
    test_pdm_clk();
    test_const(1'b1, 8'h7F, 1'b1);
    test_const(1'b0, 8'h80, 1'b0);
    test_alternating();
    test_reset_mid();
    test_enable_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
